// File: rtl/instr_fetch.sv
// Instruction-fetch stage: captures the PC, reads instruction memory over a
// req/ack handshake, latches IR and PC+4, and reports misalign/timeout faults.
module instr_fetch #(
    parameter int TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] pc_in,
    input  logic        fetch_start,
    input  logic        fault_clr,
    output logic [31:0] mem_addr,
    output logic        mem_req,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] IR,
    output logic [31:0] pc_plus4,
    output logic        fetch_done,
    output logic        busy,
    output logic        fault,
    output logic [1:0]  fault_cause
);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_REQ   = 2'b01;
    localparam logic [1:0] S_DONE  = 2'b10;
    localparam logic [1:0] S_FAULT = 2'b11;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0] state;
    logic [7:0] cnt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= S_IDLE;
            cnt         <= 8'd0;
            mem_addr    <= 32'd0;
            pc_plus4    <= 32'd0;
            IR          <= 32'd0;
            fault_cause <= 2'b00;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (fetch_start) begin
                        if (pc_in[1:0] == 2'b00) begin
                            mem_addr <= pc_in;
                            pc_plus4 <= pc_in + 32'd4;
                            cnt      <= 8'd0;
                            state    <= S_REQ;
                        end else begin
                            fault_cause <= 2'b01;
                            state       <= S_FAULT;
                        end
                    end
                end
                S_REQ: begin
                    // ack wins over a timeout landing on the same edge
                    if (mem_ack) begin
                        IR    <= mem_rdata;
                        state <= S_DONE;
                    end else if (cnt == CNT_LAST) begin
                        fault_cause <= 2'b10;
                        state       <= S_FAULT;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_DONE: state <= S_IDLE;
                S_FAULT: begin
                    if (fault_clr) begin
                        fault_cause <= 2'b00;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign mem_req    = (state == S_REQ);
    assign busy       = (state == S_REQ);
    assign fetch_done = (state == S_DONE);
    assign fault      = (state == S_FAULT);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_instr_fetch;

    logic        CLK;
    logic        RST;
    logic [31:0] pc_in;
    logic        fetch_start;
    logic        fault_clr;
    logic [31:0] mem_addr;
    logic        mem_req;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] IR;
    logic [31:0] pc_plus4;
    logic        fetch_done;
    logic        busy;
    logic        fault;
    logic [1:0]  fault_cause;

    int n_tests = 0;
    int n_fail  = 0;

    instr_fetch #(.TIMEOUT(16)) dut (
        .CLK(CLK),
        .RST(RST),
        .pc_in(pc_in),
        .fetch_start(fetch_start),
        .fault_clr(fault_clr),
        .mem_addr(mem_addr),
        .mem_req(mem_req),
        .mem_rdata(mem_rdata),
        .mem_ack(mem_ack),
        .IR(IR),
        .pc_plus4(pc_plus4),
        .fetch_done(fetch_done),
        .busy(busy),
        .fault(fault),
        .fault_cause(fault_cause)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issue one fetch; ack arrives in REQ cycle delay+1 (never if delay large).
    task automatic run_fetch(input logic [31:0] pc, input logic [31:0] data,
                             input int delay, output int nbusy);
        fetch_start = 1'b1;
        pc_in       = pc;
        mem_ack     = 1'b0;
        tick();
        fetch_start = 1'b0;
        nbusy       = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            nbusy++;
            if (nbusy == delay + 1) begin
                mem_ack   = 1'b1;
                mem_rdata = data;
            end
            tick();
            mem_ack   = 1'b0;
            mem_rdata = 32'hDEADBEEF;
        end
    endtask

    int nb;
    int nbusy_c;
    int ndone_c;

    initial begin
        RST         = 1'b1;
        pc_in       = 32'd0;
        fetch_start = 1'b0;
        fault_clr   = 1'b0;
        mem_rdata   = 32'hDEADBEEF;
        mem_ack     = 1'b0;

        #2 RST = 1'b0;
        #1;
        chk("rst_ir", IR, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_pc4", pc_plus4, 32'd0);
        chk("rst_flags", {28'd0, mem_req, fetch_done, busy, fault}, 32'd0);
        chk("rst_cause", {30'd0, fault_cause}, 32'd0);
        tick();
        #2 RST = 1'b1;
        tick();

        // basic fetch with ack in first REQ cycle
        fetch_start = 1'b1;
        pc_in       = 32'h40;
        mem_ack     = 1'b1;
        mem_rdata   = 32'h8C220004;
        tick();
        fetch_start = 1'b0;
        chk("e0_req", {31'd0, mem_req}, 32'd1);
        chk("e0_busy", {31'd0, busy}, 32'd1);
        chk("e0_done", {31'd0, fetch_done}, 32'd0);
        chk("e0_addr", mem_addr, 32'h40);
        chk("e0_pc4", pc_plus4, 32'h44);
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'hDEADBEEF;
        chk("e1_ir", IR, 32'h8C220004);
        chk("e1_done", {31'd0, fetch_done}, 32'd1);
        chk("e1_req", {31'd0, mem_req}, 32'd0);
        tick();
        chk("e2_done", {31'd0, fetch_done}, 32'd0);

        // slow memory
        run_fetch(32'h100, 32'h11112222, 5, nb);
        chk("slow_busy", nb, 6);
        chk("slow_ir", IR, 32'h11112222);
        chk("slow_done", {31'd0, fetch_done}, 32'd1);
        chk("slow_fault", {31'd0, fault}, 32'd0);
        tick();
        chk("slow_pc4", pc_plus4, 32'h104);

        // timeout with no ack
        run_fetch(32'h200, 32'h0, 100, nb);
        chk("to_busy", nb, 16);
        chk("to_fault", {31'd0, fault}, 32'd1);
        chk("to_cause", {30'd0, fault_cause}, 32'd2);
        chk("to_ir", IR, 32'h11112222);
        chk("to_req", {31'd0, mem_req}, 32'd0);
        fetch_start = 1'b1;
        pc_in       = 32'h300;
        tick();
        fetch_start = 1'b0;
        chk("to_ign", {31'd0, busy}, 32'd0);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("clr_fault", {31'd0, fault}, 32'd0);
        chk("clr_cause", {30'd0, fault_cause}, 32'd0);
        run_fetch(32'h204, 32'hA5A5A5A5, 0, nb);
        chk("after_clr_ir", IR, 32'hA5A5A5A5);
        chk("after_clr_done", {31'd0, fetch_done}, 32'd1);
        tick();

        // ack on the 16th REQ cycle still succeeds
        run_fetch(32'h208, 32'h0BADF00D, 15, nb);
        chk("ack16_busy", nb, 16);
        chk("ack16_fault", {31'd0, fault}, 32'd0);
        chk("ack16_ir", IR, 32'h0BADF00D);
        tick();

        // misaligned PC
        fetch_start = 1'b1;
        pc_in       = 32'h42;
        tick();
        fetch_start = 1'b0;
        chk("mis_fault", {31'd0, fault}, 32'd1);
        chk("mis_cause", {30'd0, fault_cause}, 32'd1);
        chk("mis_req", {31'd0, mem_req}, 32'd0);
        chk("mis_pc4", pc_plus4, 32'h20C);
        chk("mis_addr", mem_addr, 32'h208);
        tick();
        chk("mis_req2", {31'd0, mem_req}, 32'd0);
        fault_clr   = 1'b1;
        fetch_start = 1'b1;
        pc_in       = 32'h400;
        tick();
        fault_clr   = 1'b0;
        fetch_start = 1'b0;
        chk("clr_ign_start", {31'd0, busy}, 32'd0);
        chk("clr_fault2", {31'd0, fault}, 32'd0);

        // PC+4 wraps
        run_fetch(32'hFFFFFFFC, 32'h13579BDF, 0, nb);
        chk("wrap_pc4", pc_plus4, 32'h0);
        chk("wrap_addr", mem_addr, 32'hFFFFFFFC);
        tick();

        // fetch_start held high with immediate ack
        fetch_start = 1'b1;
        pc_in       = 32'h500;
        mem_ack     = 1'b1;
        mem_rdata   = 32'h00C0FFEE;
        nbusy_c     = 0;
        ndone_c     = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (busy) nbusy_c++;
            if (fetch_done) ndone_c++;
        end
        fetch_start = 1'b0;
        mem_ack     = 1'b0;
        chk("hold_busy", nbusy_c, 3);
        chk("hold_done", ndone_c, 3);
        chk("hold_ir", IR, 32'h00C0FFEE);
        tick();
        tick();

        // reset during REQ
        run_fetch(32'h600, 32'h0, 100, nb);
        fault_clr = 1'b1;
        tick();
        fault_clr   = 1'b0;
        fetch_start = 1'b1;
        pc_in       = 32'h700;
        tick();
        fetch_start = 1'b0;
        chk("rreq_busy", {31'd0, busy}, 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h77777777;
        #2 RST = 1'b0;
        #1;
        chk("rreq_req", {31'd0, mem_req}, 32'd0);
        chk("rreq_ir", IR, 32'd0);
        tick();
        chk("rreq_ir2", IR, 32'd0);
        mem_ack = 1'b0;
        #2 RST = 1'b1;
        tick();
        chk("rreq_idle", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage of the multicycle CPU. Sits directly downstream of the program counter register. On a fetch command from the control unit it captures the current PC value and performs a request/acknowledge read from instruction memory. It then latches the returned word into the instruction register and produces PC+4 for the next-PC mux. Misaligned PCs and memory timeouts are detected and reported as a sticky fault.

## Interface
- TIMEOUT, 16: maximum number of cycles `mem_req` is held without `mem_ack` before a timeout fault (legal range 2..255).
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- pc_in  in  32  current PC value, taken from the PC register output.
- fetch_start  in  1  fetch command from the control unit (IF state); sampled only in IDLE.
- fault_clr  in  1  clears a sticky fault; sampled only in FAULT.
- mem_addr  out  32  instruction memory address (the captured PC).
- mem_req  out  1  read request to instruction memory.
- mem_rdata  in  32  instruction word; valid when `mem_ack`=1.
- mem_ack  in  1  memory acknowledge; only meaningful while `mem_req`=1.
- IR  out  32  instruction register.
- pc_plus4  out  32  captured PC + 4.
- fetch_done  out  1  one-cycle pulse after `IR` is updated.
- busy  out  1  high in the REQ state.
- fault  out  1  high in the FAULT state.
- fault_cause  out  2  reason for the fault: 2'b01 misaligned, 2'b10 timeout, 2'b00 none.

## Operation
- FSM states: IDLE, REQ, DONE, FAULT. Reset state is IDLE.
- IDLE:
  - `fetch_start`=1 with `pc_in[1:0]`=0: capture `mem_addr`<=`pc_in` and `pc_plus4`<=`pc_in`+4, clear the timeout counter, go to REQ.
  - `fetch_start`=1 with `pc_in[1:0]`≠0: go to FAULT with `fault_cause`=01. No request is issued and `IR`, `mem_addr` and `pc_plus4` are unchanged.
- REQ:
  - `mem_req`=1 and `busy`=1.
  - If `mem_ack`=1 at an edge: `IR`<=`mem_rdata`, go to DONE.
  - Else if the counter equals TIMEOUT-1: go to FAULT with `fault_cause`=10.
  - Else increment the counter.
  - `mem_ack` takes priority over timeout on the same edge.
- DONE: `fetch_done`=1 for exactly one cycle, then go to IDLE. A `fetch_start` seen during DONE is ignored.
- FAULT:
  - `fault`=1, `mem_req`=0.
  - `fault_clr`=1: go to IDLE and clear `fault_cause` to 00. A `fetch_start` on the same edge is ignored.
  - All other inputs are ignored.
- `fetch_start` during REQ, DONE or FAULT is ignored; nothing is queued.
- `pc_plus4` arithmetic is modulo 2^32: 32'hFFFFFFFC produces 32'h00000000.
- `mem_addr` and `pc_plus4` hold their values until the next accepted fetch.
- `mem_rdata` is never sampled outside REQ-with-ack.

## Timing
- Reset (async, RST=0): state IDLE; `IR`, `mem_addr` and `pc_plus4` = 32'h00000000; `mem_req`, `fetch_done`, `busy` and `fault` = 0; `fault_cause` = 00; counter = 0.
- Reset mid-REQ: `mem_req` drops immediately (asynchronously) and no `IR` update occurs.
- All outputs are registered or decoded from state only; there is no combinational path from input to output.
- Accepted fetch at edge E0: `mem_req`/`busy` rise after E0.
- `mem_ack` sampled at edge E1: `IR` updates at E1, `mem_req` falls after E1, `fetch_done` is high between E1 and E2.
- Minimum latency is 2 edges from `fetch_start` to `fetch_done`, and the minimum `fetch_start`-to-`fetch_start` spacing is 3 cycles.
- Timeout: with no ack, `mem_req` stays high for exactly TIMEOUT cycles. `fault` rises on the edge that ends the TIMEOUT-th cycle, and `mem_req` falls on that same edge.
- Misaligned: `fault` rises 1 edge after the `fetch_start` edge, and `mem_req` never asserts.
- `fault_clr` sampled at edge F: `fault` low after F, and a new fetch can be accepted at F+1.

## Test plan
- Reset checks:
  - Assert RST=0 asynchronously mid-cycle → all outputs 0 immediately.
  - Release RST, then `fetch_start` with `pc_in`=32'h00000040 and `mem_ack` in the first REQ cycle with `mem_rdata`=32'h8C220004 → `mem_addr`=32'h40, `IR`=32'h8C220004, `pc_plus4`=32'h44, `fetch_done` one cycle exactly 2 edges after start.
- Slow memory: `mem_ack` delayed 5 cycles, TIMEOUT=16, `pc_in`=32'h100 → `busy` high 6 cycles, no fault, `IR` updated once.
- Timeout:
  - No ack, TIMEOUT=16 → `mem_req` high exactly 16 cycles, then `fault`=1 with `fault_cause`=10 and `IR` unchanged.
  - `fault_clr` → IDLE; the next fetch succeeds.
  - Ack arriving on cycle 16 → success, no fault.
- Misaligned: `pc_in`=32'h00000042 → `fault_cause`=01, `mem_req` never asserted, `pc_plus4` unchanged.
- Wrap and ignore:
  - `pc_in`=32'hFFFFFFFC → `pc_plus4`=32'h00000000.
  - `fetch_start` held high continuously → fetches accepted only from IDLE, one every 3 cycles with immediate ack.
  - RST asserted during REQ → `mem_req` drops at once and `IR` stays 0.
